// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Holds the clear-engine state type, width defaults and the lane slicer.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  // Base bit of lane idx on a packed bus of w-bit lanes.
  function automatic int lane(int idx, int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus bundle for regfile_mp: clear request, ready, two write ports,
// packed read addresses/data and the write-collision pulse.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2
);

  logic                     clr;
  logic                     ready;
  logic                     we0;
  logic [ADDR_W-1:0]        wa0;
  logic [DATA_W-1:0]        wd0;
  logic                     we1;
  logic [ADDR_W-1:0]        wa1;
  logic [DATA_W-1:0]        wd1;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic                     wr_collide;

  modport master (
    output clr, we0, wa0, wd0,
    output we1, wa1, wd1, ra,
    input  ready, rd, wr_collide
  );

  modport slave (
    input  clr, we0, wa0, wd0,
    input  we1, wa1, wd1, ra,
    output ready, rd, wr_collide
  );

endinterface

// File: rtl/regfile_clear_seq.sv
// Clear engine: sweeps zeros through the array after rst/clr.
// Ports: clk, rst, clr_i in; clr_we_o, clr_addr_o, ready_o out.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              ready_o
);

  rf_state_e         state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              ready_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      state_q <= RF_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        RF_CLEAR: begin
          ptr_q <= ptr_q + ADDR_W'(1);
          // last entry written this edge
          if (ptr_q == '1) begin
            state_q <= RF_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= RF_RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we_o   = (state_q == RF_CLEAR);
  assign clr_addr_o = ptr_q;
  assign ready_o    = ready_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD async reads, two writes (port 1
// wins), r0 hardwired zero, sweep clear. Ports: clk, rst, bus (slave).
// Optional same-cycle write bypass: define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              w0_en;
  logic              w1_en;
  logic              coll_d;
  logic              coll_q;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (bus.clr),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .ready_o    (ready)
  );

  // rst and clr both drop any write in the same cycle
  assign w0_en = ready && !rst && !bus.clr
              && bus.we0 && (bus.wa0 != '0);
  assign w1_en = ready && !rst && !bus.clr
              && bus.we1 && (bus.wa1 != '0);
  assign coll_d = w0_en && w1_en
               && (bus.wa0 == bus.wa1);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (w0_en && !coll_d)
        mem_q[bus.wa0] <= bus.wd0;
      if (w1_en)
        mem_q[bus.wa1] <= bus.wd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) coll_q <= 1'b0;
    else     coll_q <= coll_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_l;
    logic [DATA_W-1:0] rd_l;

    assign ra_l = bus.ra[lane(i, ADDR_W) +: ADDR_W];

    always_comb begin
      rd_l = mem_q[ra_l];
`ifdef REGFILE_BYPASS_EN
      if (w1_en && bus.wa1 == ra_l)
        rd_l = bus.wd1;
      else if (w0_en && bus.wa0 == ra_l)
        rd_l = bus.wd0;
`endif
      // array is untrusted until the sweep ends
      if (!ready || ra_l == '0)
        rd_l = '0;
    end

    assign bus.rd[lane(i, DATA_W) +: DATA_W] = rd_l;
  end

  assign bus.ready      = ready;
  assign bus.wr_collide = coll_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Random + directed bench for regfile_mp against a behavioural model.
// Model: an array of values plus a count of clear cycles remaining.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic clk;
  logic rst;

  regfile_if #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR)
  ) bus ();

  regfile_mp #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          known = 1'b0;
  int          clr_left = 0;
  logic [31:0] m [DEPTH];
  bit          exp_coll = 1'b0;

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdl(int i);
    return bus.rd[i*DW +: DW];
  endfunction

  function automatic logic [4:0] ral(int i);
    return bus.ra[i*AW +: AW];
  endfunction

  function automatic logic [31:0] exp_rd(
    logic [4:0] a
  );
    logic [31:0] v;
    if (clr_left > 0 || a == 0) return 0;
    v = m[a];
`ifdef REGFILE_BYPASS_EN
    if (!rst && !bus.clr) begin
      if (bus.we1 && bus.wa1 == a)
        v = bus.wd1;
      else if (bus.we0 && bus.wa0 == a)
        v = bus.wd0;
    end
`endif
    return v;
  endfunction

  task automatic model_edge();
    if (rst || (known && bus.clr)) begin
      known = 1'b1;
      clr_left = DEPTH;
      exp_coll = 1'b0;
      for (int k = 0; k < DEPTH; k++) m[k] = 0;
    end else if (clr_left > 0) begin
      clr_left--;
      exp_coll = 1'b0;
    end else begin
      exp_coll = bus.we0 && bus.we1
              && bus.wa0 == bus.wa1
              && bus.wa0 != 0;
      if (bus.we0 && bus.wa0 != 0)
        m[bus.wa0] = bus.wd0;
      if (bus.we1 && bus.wa1 != 0)
        m[bus.wa1] = bus.wd1;
    end
  endtask

  // called at negedge with inputs already driven
  task automatic cyc();
    #1;
    if (known)
      for (int i = 0; i < NR; i++)
        chk($sformatf("rd%0d", i),
            rdl(i), exp_rd(ral(i)));
    @(posedge clk);
    model_edge();
    #1;
    if (known) begin
      chk("ready", {31'b0, bus.ready},
          {31'b0, clr_left == 0});
      chk("coll", {31'b0, bus.wr_collide},
          {31'b0, exp_coll});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.clr = 0;
    bus.we0 = 0; bus.wa0 = 0; bus.wd0 = 0;
    bus.we1 = 0; bus.wa1 = 0; bus.wd1 = 0;
  endtask

  task automatic set_ra(logic [4:0] a0,
                        logic [4:0] a1);
    bus.ra = {a1, a0};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    idle();
    set_ra(0, 0);
    rst = 1;
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_rd0", rdl(0), 0);
    chk("rst_rdy", {31'b0, bus.ready}, 0);
    chk("rst_col", {31'b0, bus.wr_collide}, 0);
    rst = 0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.ready && n < 100);
    chk("rdy_lat", n, 32);

    for (int a = 0; a < DEPTH; a += 2) begin
      set_ra(5'(a), 5'(a + 1));
      #1;
      chk("zero_l0", rdl(0), 0);
      chk("zero_l1", rdl(1), 0);
      cyc();
    end

    // r0 write is a nop
    bus.we0 = 1; bus.wa0 = 0; bus.wd0 = 69;
    set_ra(0, 0);
    cyc();
    idle();
    cyc();
    chk("r0_nop", rdl(0), 0);

    // enable gating
    bus.we0 = 1; bus.wa0 = 1; bus.wd0 = 69;
    cyc();
    bus.we0 = 0; bus.wd0 = 55;
    cyc();
    set_ra(1, 0);
    #1;
    chk("we_gate", rdl(0), 69);

    // collision
    idle();
    bus.we0 = 1; bus.wa0 = 2; bus.wd0 = 55;
    bus.we1 = 1; bus.wa1 = 2; bus.wd1 = 77;
    cyc();
    idle();
    chk("coll_hi", {31'b0, bus.wr_collide}, 1);
    set_ra(2, 0);
    #1;
    chk("coll_dat", rdl(0), 77);
    cyc();
    chk("coll_lo", {31'b0, bus.wr_collide}, 0);
    bus.we0 = 1; bus.we1 = 1;
    bus.wd0 = 55; bus.wd1 = 77;
    cyc();
    idle();
    chk("coll_a0", {31'b0, bus.wr_collide}, 0);

    // bypass
    bus.we0 = 1; bus.wa0 = 5;
    bus.wd0 = 32'hDEADBEEF;
    set_ra(0, 5);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_pre", rdl(1), 32'hDEADBEEF);
`else
    chk("byp_pre", rdl(1), 0);
`endif
    cyc();
    idle();
    #1;
    chk("byp_post", rdl(1), 32'hDEADBEEF);

    // mid-operation clear
    bus.we0 = 1; bus.wa0 = 2; bus.wd0 = 55;
    cyc();
    bus.clr = 1;
    bus.wa0 = 3; bus.wd0 = 99;
    cyc();
    idle();
    chk("clr_rdy", {31'b0, bus.ready}, 0);
    for (int k = 0; k < 32; k++) begin
      set_ra(5'(k), 5'($urandom_range(1, 31)));
      #1;
      chk("swp_l0", rdl(0), 0);
      chk("swp_l1", rdl(1), 0);
      cyc();
    end
    chk("clr_done", {31'b0, bus.ready}, 1);
    set_ra(1, 2);
    #1;
    chk("clr_r1", rdl(0), 0);
    chk("clr_r2", rdl(1), 0);
    set_ra(3, 0);
    #1;
    chk("clr_r3", rdl(0), 0);

    // random phase
    for (int c = 0; c < 3000; c++) begin
      bus.we0 = 1'($urandom);
      bus.we1 = 1'($urandom);
      bus.wa0 = ($urandom_range(0, 3) == 0)
              ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.wa1 = ($urandom_range(0, 3) == 0)
              ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.wd0 = $urandom;
      bus.wd1 = $urandom;
      bus.clr = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 299) == 0);
      set_ra(($urandom_range(0, 1) == 0)
               ? bus.wa0 : 5'($urandom),
             ($urandom_range(0, 1) == 0)
               ? bus.wa1 : 5'($urandom));
      cyc();
    end
    rst = 0;
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the MIPS datapath; successor to the single-write, two-read 32x32 register file. It provides `NUM_RD` asynchronous read ports, two prioritised write ports for a dual-issue writeback stage, and a hardwired-zero register 0. A sequential clear engine zeroes the array after reset or on request and holds `ready` low while it runs.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; `DEPTH = 2**ADDR_W` registers
- `NUM_RD`, 2, number of asynchronous read ports (1..4)

- `clk`  in  1  sole clock, rising-edge
- `rst`  in  1  synchronous, active-high reset
- `clr`  in  1  single-cycle request to re-zero the whole array
- `ready`  out  1  high when the array is usable
- `we0`  in  1  write enable, port 0
- `wa0`  in  ADDR_W  write address, port 0
- `wd0`  in  DATA_W  write data, port 0
- `we1`  in  1  write enable, port 1 (higher priority)
- `wa1`  in  ADDR_W  write address, port 1
- `wd1`  in  DATA_W  write data, port 1
- `ra`  in  NUM_RD*ADDR_W  packed read addresses; port i is at `[i*ADDR_W +: ADDR_W]`
- `rd`  out  NUM_RD*DATA_W  packed read data; port i is at `[i*DATA_W +: DATA_W]`
- `wr_collide`  out  1  registered pulse: both write ports targeted the same nonzero address

## Operation
- The FSM has two states, CLEAR and RUN.
- Reset forces CLEAR with the sweep pointer at 0 and `ready`=0.
- In CLEAR, the FSM writes zero to entry `ptr` each cycle, then increments `ptr`.
  - After it writes `DEPTH-1`, the next state is RUN.
- `clr` asserted in RUN sends the FSM to CLEAR with `ptr`=0 on the next edge.
- `clr` asserted in CLEAR restarts the sweep at `ptr`=0.
- In CLEAR, both write ports are ignored and every `rd` lane reads 0.
- In RUN, a write with `weN`=1 and `waN`!=0 updates the entry on the rising edge.
  - Writes to address 0 are dropped.
- If both ports are enabled to the same address, port 1's data is stored.
  - `wr_collide` pulses for 1 cycle after that edge when the shared address is nonzero.
- Reads are combinational from `ra`.
  - A read of address 0 always returns 0.
  - Otherwise the read returns the stored entry, subject to bypass (see Configuration).
- `rst` asserted mid-sweep or mid-operation restarts CLEAR at `ptr`=0. Data already in the array is not trusted.

## Timing
- Reset values: `ready`=0, `wr_collide`=0, all `rd` lanes 0.
- Clear latency: `ready` rises `DEPTH` cycles after the last cycle with `rst` or `clr` high. With the default parameters this is 32 cycles.
- Write latency: data is visible on a read of the same address from the next cycle (same cycle with bypass).
- Read latency: zero cycles, combinational from `ra` and the array.
- `ready` is registered and glitch-free.
- `rst` takes priority over `clr`. `clr` takes priority over any write presented in the same cycle; that write is dropped.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - In RUN, a read whose address matches an enabled nonzero write address returns that write's data in the same cycle.
  - If both ports match, port 1's data is returned.
  - The bypass path adds the write-mux delay to the read path.
- `REGFILE_BYPASS_EN` undefined:
  - Reads return the array contents only. A same-cycle write shows up on the read port after the edge.
- The macro affects read-path logic only. State, clear behaviour and `wr_collide` are identical in both builds.

## Structure
- Package `regfile_pkg` holds:
  - the FSM state typedef (`RF_CLEAR`, `RF_RUN`);
  - `localparam` defaults for `DATA_W` and `ADDR_W`;
  - a `lane` helper constant for packed-bus slicing.
- Sub-module `regfile_clear_seq` holds:
  - the state register, sweep pointer and `ready`;
  - outputs `clr_we`, `clr_addr` and `ready` to the top level.
- The top level holds the array, the write-priority mux, the read lanes, bypass and `wr_collide`.

## Test plan
- Reset and clear: pulse `rst` for 2 cycles, then poll.
  - `ready`=0 for exactly 32 cycles after `rst` falls, then 1.
  - All 32 entries then read 0.
- Register-zero nop: `we0`=1, `wa0`=0, `wd0`=69; read `ra` lane 0 = 0.
  - `rd` lane 0 = 0 after the edge and thereafter.
- Write enable gating: write 69 to r1. Then present `we0`=0, `wa0`=1, `wd0`=55 for 1 cycle.
  - r1 still reads 69.
- Dual-write collision: `we0`=`we1`=1, `wa0`=`wa1`=2, `wd0`=55, `wd1`=77.
  - r2 reads 77.
  - `wr_collide`=1 for exactly 1 cycle.
  - Repeating with both addresses 0 gives `wr_collide`=0.
- Bypass: write 0xDEADBEEF to r5 while lane 1 reads r5.
  - With `REGFILE_BYPASS_EN`, lane 1 shows 0xDEADBEEF before the edge.
  - Without it, lane 1 shows the old value 0 until after the edge.
- Mid-operation clear: load r1=69 and r2=55, assert `clr` together with a write of 99 to r3.
  - `ready` falls on the next cycle.
  - All lanes read 0 during the sweep.
  - After 32 cycles, r1, r2 and r3 all read 0.
